i2c_slave_regfile: RTL



---
 rtl/i2c_slave_regfile.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and a
// local fabric-side register port. Split open-drain SDA (sda_oe pulls low).
`timescale 1ns/1ps

module i2c_slave_regfile #(
   parameter logic [6:0] SLV_ADDR = 7'h2D,
   parameter int         DEPTH    = 16,
   parameter int         PW       = $clog2(DEPTH),
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   output logic          busy,
   output logic          wr_stb,
   output logic [PW-1:0] wr_idx,
   output logic [7:0]    wr_dat,
   input  logic          lcl_we,
   input  logic [PW-1:0] lcl_idx,
   input  logic [7:0]    lcl_wdat,
   output logic [7:0]    lcl_rdat
);

   // state     | meaning
   // IDLE      | bus free, waiting for START
   // ADDR      | shifting in address + R/W
   // ADDR_ACK  | driving ACK for our address
   // PTR       | shifting in register pointer
   // PTR_ACK   | driving ACK for a valid pointer
   // WDATA     | shifting in a write byte
   // WDATA_ACK | driving ACK for a committed byte
   // RDATA     | shifting out a read byte
   // RDATA_ACK | sampling the master's ACK/NACK
   // IGNORE    | not addressed / NACKed, waiting for START or STOP
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   localparam logic [PW:0]   DEPTH_L = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

   state_t        state, state_nxt;
   logic [2:0]    scl_q, sda_q;
   logic [7:0]    sh, sh_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          rw, rw_nxt;
   logic          mst_nack, mst_nack_nxt;
   logic [PW-1:0] ptr, ptr_nxt, ptr_inc;
   logic [7:0]    tx, tx_nxt;
   logic          oe_nxt, busy_nxt, stb_nxt;
   logic [PW-1:0] idx_nxt;
   logic [7:0]    dat_nxt, rd_byte;
   logic          scl_rise, scl_fall, start_det, stop_det, sda_s, ptr_fits;
   logic [7:0]    regs [DEPTH];

   // [1:0] synchroniser, [2] edge-detect delay; reset high to match an idle bus
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign ptr_inc   = (ptr == LAST) ? '0 : ptr + 1'b1;
   assign ptr_fits  = ({1'b0, sh} < 9'(DEPTH));
   assign rd_byte   = regs[ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         sh       <= '0;
         cnt      <= '0;
         rw       <= 1'b0;
         mst_nack <= 1'b0;
         ptr      <= '0;
         tx       <= '0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_stb   <= 1'b0;
         wr_idx   <= '0;
         wr_dat   <= '0;
      end else begin
         state    <= state_nxt;
         sh       <= sh_nxt;
         cnt      <= cnt_nxt;
         rw       <= rw_nxt;
         mst_nack <= mst_nack_nxt;
         ptr      <= ptr_nxt;
         tx       <= tx_nxt;
         sda_oe   <= oe_nxt;
         busy     <= busy_nxt;
         wr_stb   <= stb_nxt;
         wr_idx   <= idx_nxt;
         wr_dat   <= dat_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      sh_nxt       = sh;
      cnt_nxt      = cnt;
      rw_nxt       = rw;
      mst_nack_nxt = mst_nack;
      ptr_nxt      = ptr;
      tx_nxt       = tx;
      oe_nxt       = sda_oe;
      busy_nxt     = busy;
      stb_nxt      = 1'b0;
      idx_nxt      = wr_idx;
      dat_nxt      = wr_dat;
      if (stop_det) begin
         state_nxt = IDLE;
         oe_nxt    = 1'b0;
         busy_nxt  = 1'b0;
         cnt_nxt   = '0;
      end else if (start_det) begin
         state_nxt = ADDR;
         oe_nxt    = 1'b0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  sh_nxt  = {sh[6:0], sda_s};
                  cnt_nxt = cnt + 1'b1;
               end else if (scl_fall && cnt == 4'd8) begin
                  cnt_nxt = '0;
                  if (state == ADDR) begin
                     if (sh[7:1] == SLV_ADDR) begin
                        state_nxt = ADDR_ACK;
                        oe_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        rw_nxt    = sh[0];
                     end else begin
                        state_nxt = IGNORE;
                        oe_nxt    = 1'b0;
                     end
                  end else if (state == PTR) begin
                     if (ptr_fits) begin
                        ptr_nxt   = sh[PW-1:0];
                        state_nxt = PTR_ACK;
                        oe_nxt    = 1'b1;
                     end else begin
                        state_nxt = IGNORE;
                        oe_nxt    = 1'b0;
                     end
                  end else begin
                     stb_nxt   = 1'b1;
                     idx_nxt   = ptr;
                     dat_nxt   = sh;
                     ptr_nxt   = ptr_inc;
                     state_nxt = WDATA_ACK;
                     oe_nxt    = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw) begin
                     state_nxt = RDATA;
                     tx_nxt    = rd_byte;
                     oe_nxt    = ~rd_byte[7];
                  end else begin
                     state_nxt = PTR;
                     oe_nxt    = 1'b0;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  state_nxt = WDATA;
                  oe_nxt    = 1'b0;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_nxt = cnt + 1'b1;
               end else if (scl_fall && cnt == 4'd8) begin
                  cnt_nxt   = '0;
                  oe_nxt    = 1'b0;
                  ptr_nxt   = ptr_inc;
                  state_nxt = RDATA_ACK;
               end else if (scl_fall && cnt != 4'd0) begin
                  oe_nxt = ~tx[6];
                  tx_nxt = {tx[6:0], 1'b0};
               end
            end
            RDATA_ACK: begin
               if (scl_rise) begin
                  mst_nack_nxt = sda_s;
                  cnt_nxt      = 4'd1;
               end else if (scl_fall && cnt == 4'd1) begin
                  cnt_nxt = '0;
                  if (!mst_nack) begin
                     state_nxt = RDATA;
                     tx_nxt    = rd_byte;
                     oe_nxt    = ~rd_byte[7];
                  end else begin
                     state_nxt = IGNORE;
                     oe_nxt    = 1'b0;
                  end
               end
            end
            IGNORE:  oe_nxt = 1'b0;
            default: ;
         endcase
      end
   end

   // I2C commit lands the cycle wr_stb is high and wins over a local write to the same index
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      end else begin
         if (lcl_we && ({1'b0, lcl_idx} < DEPTH_L) && !(wr_stb && wr_idx == lcl_idx))
            regs[lcl_idx] <= lcl_wdat;
         if (wr_stb)
            regs[wr_idx] <= wr_dat;
      end
   end

   assign lcl_rdat = ({1'b0, lcl_idx} < DEPTH_L) ? regs[lcl_idx] : RST_VAL;

endmodule
